dmem_arbiter: RTL and testbench

Two-port arbiter/sequencer in front of the 1024-byte big-endian data memory.
- Shares the single memory port between the CPU data path (MEM stage) and a debug/loader port.
- Uses round-robin arbitration, a req/gnt handshake and a registered response.
- Sequences each access as GRANT → ACCESS → RESP.
- Enforces the word range check (addr ≤ MEM_BYTES-4) so out-of-range accesses never reach the memory.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 21 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding, port
// ownership, default memory geometry and the word range-check helper.
package dmem_pkg;

  localparam int unsigned DEFAULT_MEM_BYTES = 1024;
  localparam int unsigned DATA_W            = 32;
  localparam logic [31:0] LAST_WORD_ADDR    = 32'(DEFAULT_MEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Unsigned compare, so huge addresses (e.g. 0xFFFF_FFFC) are rejected too.
  function automatic logic word_in_range(input logic [31:0] addr,
                                         input logic [31:0] last_addr);
    return addr <= last_addr;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response port of the data-memory arbiter.
//   master : requester side (CPU MEM stage or debug/loader)
//   slave  : arbiter side
// req/we/addr/wdata flow master->slave; gnt/rvalid/rdata/err flow back.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, addr, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   i_req[0] = CPU, i_req[1] = debug
//   i_adv    : arbitration point; the pointer only moves when a grant is issued here
//   o_gnt    : one-hot grant (combinational)
// Pointer remembers which port was granted last; on a tie the other one wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_last_dbg;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_dbg ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Reset points at debug so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)
      r_last_dbg <= 1'b1;
    else if (i_adv && (|o_gnt))
      r_last_dbg <= o_gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the big-endian data memory.
//   clk, reset         : system clock, synchronous active-high reset
//   cpu, dbg           : requester ports (req/gnt handshake, registered response)
//   mem_addr/wdata/we  : memory port, driven from the latched request
//   mem_rdata          : combinational read data from the memory
//   busy               : high while an access is in ACCESS or RESP
//
// state  | meaning
// IDLE   | no access in flight; arbitrate
// ACCESS | latched request on the memory port; capture read data
// RESP   | owner's rvalid pulse; arbitrate for the next access
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int unsigned DW        = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave cpu,
  dmem_arbiter_if.slave dbg,
  output logic [31:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  state_t        r_state, w_state_nxt;
  owner_t        r_owner;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_arb_en;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  owner_t        w_win;
  logic          w_in_range;
  logic          w_resp;

  // Arbitration runs in IDLE and RESP; reset blocks any grant.
  assign w_arb_en = !reset && (r_state != ST_ACCESS);
  assign w_req    = {dbg.req, cpu.req} & {2{w_arb_en}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .i_req (w_req),
    .i_adv (w_arb_en),
    .o_gnt (w_gnt)
  );

  assign w_win      = w_gnt[1] ? OWN_DBG : OWN_CPU;
  assign w_in_range = word_in_range(r_addr, LAST_ADDR);
  assign w_resp     = !reset && (r_state == ST_RESP);

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_gnt) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_we      = r_we && w_in_range && !reset;
        busy        = !reset;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        busy        = !reset;
        w_state_nxt = (|w_gnt) ? ST_ACCESS : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // mem_addr/mem_wdata come straight from the request latch, which only
  // changes on the edge entering ACCESS, so they hold outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (|w_gnt) begin
        r_owner <= w_win;
        r_we    <= (w_win == OWN_DBG) ? dbg.we    : cpu.we;
        r_addr  <= (w_win == OWN_DBG) ? dbg.addr  : cpu.addr;
        r_wdata <= (w_win == OWN_DBG) ? dbg.wdata : cpu.wdata;
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= (!r_we && w_in_range) ? mem_rdata : '0;
        r_err   <= !w_in_range;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign cpu.gnt    = w_gnt[0];
  assign dbg.gnt    = w_gnt[1];
  assign cpu.rvalid = w_resp && (r_owner == OWN_CPU);
  assign dbg.rvalid = w_resp && (r_owner == OWN_DBG);
  assign cpu.rdata  = cpu.rvalid ? r_rdata : '0;
  assign dbg.rdata  = dbg.rvalid ? r_rdata : '0;
  assign cpu.err    = cpu.rvalid && r_err;
  assign dbg.err    = dbg.rvalid && r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  always #5 clk = ~clk;

  dmem_arbiter_if cpu_if ();
  dmem_arbiter_if dbg_if ();

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .dbg       (dbg_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // memory attached to the DUT, and the reference copy kept by the model
  logic [7:0] mem_arr [0:1023];
  logic [7:0] ref_mem [0:1023];

  assign mem_rdata = {mem_arr[mem_addr[9:0]],         mem_arr[mem_addr[9:0] + 10'd1],
                      mem_arr[mem_addr[9:0] + 10'd2], mem_arr[mem_addr[9:0] + 10'd3]};

  int n_cmp = 0, n_mis = 0;
  int cyc = 0, last_g = -10, last_own = 1;
  bit rand_mode = 0;
  bit pending [2], pulsed [2], force_pulse [2];
  logic        p_we [2];
  logic [31:0] p_addr [2], p_wd [2];
  bit acc_v = 0; int acc_c, acc_own; logic acc_we; logic [31:0] acc_addr, acc_wd;
  bit rsp_v = 0; int rsp_c, rsp_own; logic [31:0] rsp_data; logic rsp_err;
  int obs_log [$];
  logic [31:0] obs_rdata [2];
  logic        obs_err [2];
  int we_seen = 0, rv_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return {ref_mem[a[9:0]], ref_mem[a[9:0] + 10'd1], ref_mem[a[9:0] + 10'd2], ref_mem[a[9:0] + 10'd3]};
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a[9:0]]         = d[31:24];
    ref_mem[a[9:0] + 10'd1] = d[23:16];
    ref_mem[a[9:0] + 10'd2] = d[15:8];
    ref_mem[a[9:0] + 10'd3] = d[7:0];
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      6:       return 32'd1020;
      7:       return 32'd1021;
      8:       return 32'd1016 + 32'($urandom_range(0, 8));
      9:       return $urandom;
      default: return 32'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic post(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    pending[p] = 1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
  endtask

  task automatic drive_ports();
    cpu_if.req = pending[0] | pulsed[0]; cpu_if.we = p_we[0];
    cpu_if.addr = p_addr[0]; cpu_if.wdata = p_wd[0];
    dbg_if.req = pending[1] | pulsed[1]; dbg_if.we = p_we[1];
    dbg_if.addr = p_addr[1]; dbg_if.wdata = p_wd[1];
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, compare
  // against the transaction-level model, then advance the model.
  task automatic run_cycle(input bit rst_now);
    bit   arb_ok, in_r;
    int   win;
    bit   exp_rv [2];
    logic [31:0] exp_rd [2];
    logic exp_er [2];
    logic exp_we, exp_busy;
    logic [31:0] act_rv [2], act_rd [2], act_er [2], act_gnt [2];
    @(negedge clk);
    reset  = rst_now;
    arb_ok = (cyc != last_g + 1);
    for (int p = 0; p < 2; p++) begin
      pulsed[p] = 0;
      if (!pending[p]) begin
        if (!arb_ok && (force_pulse[p] || (rand_mode && $urandom_range(0, 3) == 0))) begin
          force_pulse[p] = 0; pulsed[p] = 1; p_we[p] = 1'b1;
          p_addr[p] = 32'($urandom_range(0, 1020)); p_wd[p] = $urandom;
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          post(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
    end
    drive_ports();
    #1;
    win = -1;
    if (!rst_now && arb_ok) begin
      if (pending[0] && pending[1]) win = (last_own == 0) ? 1 : 0;
      else if (pending[0])          win = 0;
      else if (pending[1])          win = 1;
    end
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = !rst_now && rsp_v && (rsp_c == cyc) && (rsp_own == p);
      exp_rd[p] = exp_rv[p] ? rsp_data : 32'd0;
      exp_er[p] = exp_rv[p] ? rsp_err : 1'b0;
    end
    exp_we   = !rst_now && acc_v && (acc_c == cyc) && acc_we && (acc_addr <= LAST_WORD_ADDR);
    exp_busy = !rst_now && ((cyc == last_g + 1) || (cyc == last_g + 2));
    act_gnt[0] = 32'(cpu_if.gnt);    act_gnt[1] = 32'(dbg_if.gnt);
    act_rv[0]  = 32'(cpu_if.rvalid); act_rv[1]  = 32'(dbg_if.rvalid);
    act_rd[0]  = cpu_if.rdata;       act_rd[1]  = dbg_if.rdata;
    act_er[0]  = 32'(cpu_if.err);    act_er[1]  = 32'(dbg_if.err);
    for (int p = 0; p < 2; p++) begin
      check_val(p == 0 ? "cpu_gnt" : "dbg_gnt", act_gnt[p], 32'(win == p));
      check_val(p == 0 ? "cpu_rvalid" : "dbg_rvalid", act_rv[p], 32'(exp_rv[p]));
      check_val(p == 0 ? "cpu_rdata" : "dbg_rdata", act_rd[p], exp_rd[p]);
      check_val(p == 0 ? "cpu_err" : "dbg_err", act_er[p], 32'(exp_er[p]));
      if (act_gnt[p] == 32'd1) obs_log.push_back(p);
      if (act_rv[p] == 32'd1) begin
        obs_rdata[p] = act_rd[p]; obs_err[p] = act_er[p][0]; rv_seen++;
      end
    end
    check_val("mem_we", 32'(mem_we), 32'(exp_we));
    check_val("busy", 32'(busy), 32'(exp_busy));
    if (!rst_now && acc_v && acc_c == cyc) check_val("mem_addr", mem_addr, acc_addr);
    if (exp_we) check_val("mem_wdata", mem_wdata, acc_wd);
    if (mem_we === 1'b1) begin
      we_seen++;
      mem_arr[mem_addr[9:0]]         = mem_wdata[31:24];
      mem_arr[mem_addr[9:0] + 10'd1] = mem_wdata[23:16];
      mem_arr[mem_addr[9:0] + 10'd2] = mem_wdata[15:8];
      mem_arr[mem_addr[9:0] + 10'd3] = mem_wdata[7:0];
    end
    if (rst_now) begin
      acc_v = 0; rsp_v = 0; last_own = 1; last_g = -10;
    end else begin
      if (rsp_v && rsp_c == cyc) rsp_v = 0;
      if (acc_v && acc_c == cyc) begin
        in_r     = (acc_addr <= LAST_WORD_ADDR);
        rsp_v    = 1; rsp_c = cyc + 1; rsp_own = acc_own;
        rsp_err  = !in_r;
        rsp_data = (!acc_we && in_r) ? ref_rd(acc_addr) : 32'd0;
        if (acc_we && in_r) ref_wr(acc_addr, acc_wd);
        acc_v = 0;
      end
      if (win >= 0) begin
        acc_v = 1; acc_c = cyc + 1; acc_own = win;
        acc_we = p_we[win]; acc_addr = p_addr[win]; acc_wd = p_wd[win];
        pending[win] = 0; last_own = win; last_g = cyc;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      run_cycle(0);
      n++;
    end while ((pending[0] || pending[1] || acc_v || rsp_v) && n < 40);
    if (pending[0] || pending[1] || acc_v || rsp_v) check_val("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, rv0, diffs;
    logic [31:0] prior8, t32;
    for (int i = 0; i < 1024; i++) begin
      t32 = $urandom;
      mem_arr[i] = t32[7:0];
      ref_mem[i] = t32[7:0];
    end
    for (int p = 0; p < 2; p++) begin
      pending[p] = 0; pulsed[p] = 0; force_pulse[p] = 0;
      p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0;
      obs_rdata[p] = 0; obs_err[p] = 0;
    end
    drive_ports();

    // reset state
    repeat (3) run_cycle(1);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);

    // write then read back at 16
    we0 = we_seen;
    post(0, 1'b1, 32'd16, 32'hDEADBEEF);
    run_cycle(0);
    post(0, 1'b0, 32'd16, 32'd0);
    repeat (4) run_cycle(0);
    check_val("t1_rdata", obs_rdata[0], 32'hDEADBEEF);
    check_val("t1_err", 32'(obs_err[0]), 32'd0);
    check_val("t1_we_cycles", 32'(we_seen - we0), 32'd1);

    // both ports held: alternating grants starting with the CPU
    run_cycle(1);
    obs_log.delete();
    for (int i = 0; i < 7; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pending[p]) post(p, 1'($urandom_range(0, 1)), 32'($urandom_range(32, 96)), $urandom);
      run_cycle(0);
    end
    drain();
    check_val("t2_ngrants", 32'(obs_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < obs_log.size(); i++)
      check_val("t2_order", 32'(obs_log[i]), 32'(i % 2));

    // upper boundary: 1020 legal, 1021 illegal
    post(0, 1'b1, 32'd1020, 32'hA5A50F0F); drain();
    we0 = we_seen;
    post(0, 1'b1, 32'd1021, 32'h01020304); drain();
    check_val("t3_no_we_1021", 32'(we_seen - we0), 32'd0);
    check_val("t3_wr_err_1021", 32'(obs_err[0]), 32'd1);
    post(0, 1'b0, 32'd1020, 32'd0); drain();
    check_val("t3_rd_1020", obs_rdata[0], 32'hA5A50F0F);
    check_val("t3_err_1020", 32'(obs_err[0]), 32'd0);
    post(0, 1'b0, 32'd1021, 32'd0); drain();
    check_val("t3_rd_1021", obs_rdata[0], 32'd0);
    check_val("t3_err_1021", 32'(obs_err[0]), 32'd1);

    // big-endian misaligned read across a debug-written word
    post(1, 1'b1, 32'h100, 32'h11223344); drain();
    post(0, 1'b0, 32'h102, 32'd0); drain();
    t32 = obs_rdata[0];
    check_val("t4_upper_half", 32'(t32[31:16]), 32'h3344);
    check_val("t4_err", 32'(obs_err[0]), 32'd0);

    // reset during ACCESS of a write
    prior8 = ref_rd(32'd8);
    we0 = we_seen; rv0 = rv_seen;
    post(0, 1'b1, 32'd8, 32'hCAFEF00D);
    run_cycle(0);
    run_cycle(1);
    run_cycle(0);
    check_val("t5_no_we", 32'(we_seen - we0), 32'd0);
    check_val("t5_no_rvalid", 32'(rv_seen - rv0), 32'd0);
    obs_log.delete();
    post(0, 1'b0, 32'd8, 32'd0);
    post(1, 1'b0, 32'd12, 32'd0);
    drain();
    check_val("t5_tie_cpu", 32'(obs_log.size() > 0 ? obs_log[0] : 9), 32'd0);
    check_val("t5_prior8", obs_rdata[0], prior8);

    // debug pulse during a CPU ACCESS is ignored
    obs_log.delete(); rv0 = rv_seen;
    post(0, 1'b0, 32'd40, 32'd0);
    run_cycle(0);
    force_pulse[1] = 1;
    run_cycle(0);
    run_cycle(0);
    run_cycle(0);
    check_val("t6_grants", 32'(obs_log.size()), 32'd1);
    check_val("t6_rvalids", 32'(rv_seen - rv0), 32'd1);
    check_val("t6_idle", 32'(busy), 32'd0);

    // randomized traffic with occasional resets
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) run_cycle($urandom_range(0, 299) == 0);
    rand_mode = 0;
    drain();

    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem_arr[i] !== ref_mem[i]) diffs++;
    check_val("final_mem_bytes_differing", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
